// File: rtl/glb_bank_mem_initiator.sv
// Request-side initiator for one global-buffer bank memory: registered issue stage,
// fixed-latency read capture, and a credit-protected first-word-fall-through response FIFO.
module glb_bank_mem_initiator #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 3,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic [DATA_WIDTH-1:0]   mem_data_in_bit_sel,
  input  logic [DATA_WIDTH-1:0]   mem_data_out,
  output logic                    busy
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic                  accept, accept_wr, accept_rd, push, pop;
  logic [CNT_W-1:0]      used, fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] strb_mask;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [RD_LATENCY:1]   vld_pipe;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from the registered credit count only, so a pop frees a credit next cycle.
  assign req_ready = (used < CNT_W'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign accept_wr = accept & req_wr;
  assign accept_rd = accept & ~req_wr;
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = vld_pipe[RD_LATENCY];
  assign rsp_data  = rsp_valid ? fifo_q[rd_ptr] : '0;
  assign busy      = (used != '0);

  for (genvar i = 0; i < STRB_W; i++) begin : g_strb
    assign strb_mask[8*i +: 8] = {8{req_strb[i]}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ren             <= 1'b0;
      mem_wen             <= 1'b0;
      mem_addr            <= '0;
      mem_data_in         <= '0;
      mem_data_in_bit_sel <= '0;
    end else begin
      mem_ren             <= accept_rd;
      mem_wen             <= accept_wr;
      if (accept) mem_addr <= req_addr;
      mem_data_in         <= accept_wr ? req_data  : '0;
      mem_data_in_bit_sel <= accept_wr ? strb_mask : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      used <= '0;
    end else begin
      case ({accept_rd, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  // Tracks issued reads so memory data is captured exactly RD_LATENCY cycles after ren.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= mem_ren;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= mem_data_out;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credits bound FIFO occupancy plus reads in flight, so a push into a full FIFO is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && fifo_cnt == CNT_W'(RSP_DEPTH)));

endmodule

// File: tb/tb_glb_bank_mem_initiator.sv
// Directed bench for glb_bank_mem_initiator: vector table for the issue stage and read
// latency, plus hand sequences for ordering, credits, pop+accept, random traffic, reset.
module tb_glb_bank_mem_initiator;
  localparam int AW = 17;
  localparam int DW = 64;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [SW-1:0] req_strb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          mem_ren, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_in_bit_sel, mem_data_out;
  logic          busy;

  always #5 clk = ~clk;

  glb_bank_mem_initiator dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_in_bit_sel(mem_data_in_bit_sel),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [DW-1:0] exp_sel;
    logic [DW-1:0] exp_din;
    logic [DW-1:0] exp_rsp;
  } vec_t;

  int            chk_cnt = 0;
  int            pass_cnt = 0;
  bit            rand_mode = 1'b0;
  int            nrd = 0;
  int            nrsp = 0;
  logic [DW-1:0] bank    [128];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] md1, md2;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];

  initial begin
    for (int i = 0; i < 128; i++) begin
      bank[i]    = '0;
      ref_mem[i] = '0;
    end
    md1 = '0;
    md2 = '0;
    mem_data_out = '0;
  end

  // Bank memory model: read data sampled at the end of the ren cycle, visible 3 cycles after ren.
  always @(posedge clk) begin
    if (mem_wen)
      bank[mem_addr[9:3]] <= (bank[mem_addr[9:3]] & ~mem_data_in_bit_sel) |
                             (mem_data_in & mem_data_in_bit_sel);
    md1          <= mem_ren ? bank[mem_addr[9:3]] : 64'h0;
    md2          <= md1;
    mem_data_out <= md2;
  end

  function automatic logic [DW-1:0] expand(input logic [SW-1:0] s);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < SW; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Scoreboard: reference memory updated in acceptance order; responses popped in order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid && rsp_ready) begin
        got_q.push_back(rsp_data);
        nrsp++;
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
        else chk("rsp_order", rsp_data, exp_q.pop_front());
      end
      if (req_valid && req_ready) begin
        if (req_wr)
          ref_mem[req_addr[9:3]] = (ref_mem[req_addr[9:3]] & ~expand(req_strb)) |
                                   (req_data & expand(req_strb));
        else begin
          exp_q.push_back(ref_mem[req_addr[9:3]]);
          nrd++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // Returns 1 ns after the acceptance edge with req_valid dropped.
  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s);
    int n;
    n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_data = d; req_strb = s;
    while (!req_ready && n < 100) begin step(); n++; end
    if (n >= 100) chk("req_ready_timeout", 64'd0, 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 200) begin step(); k++; end
    chk("rsp_count", 64'(got_q.size()), 64'(n));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin step(); k++; end
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"},  {62'd0, mem_ren, mem_wen}, 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_din"}, mem_data_in, 64'd0);
    chk({tag, "_bit_sel"}, mem_data_in_bit_sel, 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
  endtask

  vec_t tbl [8];

  initial begin
    int  acc;
    bit  bad;
    vec_t v;

    tbl[0] = '{1'b1, 17'h0010, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 64'hDEADBEEF_CAFEF00D, 64'h0};
    tbl[1] = '{1'b0, 17'h0010, 64'h0, 8'h00, 64'h0, 64'h0, 64'hDEADBEEF_CAFEF00D};
    tbl[2] = '{1'b1, 17'h0020, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'h0};
    tbl[3] = '{1'b1, 17'h0020, 64'h0, 8'h0F, 64'h00000000_FFFFFFFF, 64'h0, 64'h0};
    tbl[4] = '{1'b0, 17'h0020, 64'h0, 8'h00, 64'h0, 64'h0, 64'hFFFFFFFF_00000000};
    tbl[5] = '{1'b1, 17'h0028, 64'h11223344_55667788, 8'hA5, 64'hFF00FF00_00FF00FF, 64'h11223344_55667788, 64'h0};
    tbl[6] = '{1'b1, 17'h0028, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 64'h0};
    tbl[7] = '{1'b0, 17'h0028, 64'h0, 8'h00, 64'h0, 64'h0, 64'h11003300_00660088};

    reset_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_data = '0; req_strb = '0; rsp_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    step(); step();
    reset_n = 1'b1;
    step();

    // Vector table: issue-stage fields, idle cycle, and exact read latency.
    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      send(v.wr, v.addr, v.data, v.strb);
      chk($sformatf("v%0d_wen", i), 64'(mem_wen), 64'(v.wr));
      chk($sformatf("v%0d_ren", i), 64'(mem_ren), 64'(!v.wr));
      chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(v.addr));
      chk($sformatf("v%0d_bit_sel", i), mem_data_in_bit_sel, v.exp_sel);
      chk($sformatf("v%0d_din", i), mem_data_in, v.exp_din);
      step();
      chk($sformatf("v%0d_idle_en", i), {62'd0, mem_ren, mem_wen}, 64'd0);
      chk($sformatf("v%0d_idle_sel_din", i), mem_data_in_bit_sel | mem_data_in, 64'd0);
      chk($sformatf("v%0d_addr_hold", i), 64'(mem_addr), 64'(v.addr));
      if (!v.wr) begin
        step(); step();
        chk($sformatf("v%0d_rsp_early", i), 64'(rsp_valid), 64'd0);
        step();
        chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'd1);
        chk($sformatf("v%0d_rsp_data", i), rsp_data, v.exp_rsp);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
      end
    end

    // Read before and after a write to the same address, back to back.
    got_q.delete();
    send(1'b0, 17'h0010, 64'h0, 8'h00);
    send(1'b1, 17'h0010, 64'h01234567_89ABCDEF, 8'hFF);
    send(1'b0, 17'h0010, 64'h0, 8'h00);
    rsp_ready = 1'b1;
    wait_got(2);
    chk("order_old", got_q[0], 64'hDEADBEEF_CAFEF00D);
    chk("order_new", got_q[1], 64'h01234567_89ABCDEF);
    wait_idle();

    // Credit exhaustion: 6 reads offered with rsp_ready low.
    for (int k = 0; k < 6; k++) send(1'b1, 17'(17'h40 + k*8), 64'hC0DE0000_00000000 | 64'(k), 8'hFF);
    rsp_ready = 1'b0;
    got_q.delete();
    acc = 0;
    req_valid = 1'b1; req_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 17'(17'h40 + acc*8);
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    chk("credit_accepted", 64'(acc), 64'd4);
    chk("credit_ready_low", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    wait_got(4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      chk($sformatf("credit_rsp%0d", k), got_q[k], 64'hC0DE0000_00000000 | 64'(k));
    send(1'b0, 17'h60, 64'h0, 8'h00);
    send(1'b0, 17'h68, 64'h0, 8'h00);
    wait_got(6);
    for (int k = 4; k < 6 && k < got_q.size(); k++)
      chk($sformatf("credit_rsp%0d", k), got_q[k], 64'hC0DE0000_00000000 | 64'(k));
    wait_idle();

    // Pop and accept in the same cycle with three credits in use.
    rsp_ready = 1'b0;
    got_q.delete();
    send(1'b0, 17'h40, 64'h0, 8'h00);
    send(1'b0, 17'h48, 64'h0, 8'h00);
    send(1'b0, 17'h50, 64'h0, 8'h00);
    for (int k = 0; k < 20 && !rsp_valid; k++) step();
    chk("pa_rsp_valid", 64'(rsp_valid), 64'd1);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 17'h58;
    rsp_ready = 1'b1;
    chk("pa_ready_before", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("pa_ready_after", 64'(req_ready), 64'd1);
    send(1'b0, 17'h60, 64'h0, 8'h00);
    chk("pa_full_after_one_more", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    wait_got(5);
    for (int k = 0; k < 5 && k < got_q.size(); k++)
      chk($sformatf("pa_rsp%0d", k), got_q[k], 64'hC0DE0000_00000000 | 64'(k));
    wait_idle();

    // Sustained random traffic against the scoreboard.
    nrd = 0; nrsp = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send(1'($urandom_range(0, 1)), 17'(17'h100 + $urandom_range(0, 7)*8),
           {$urandom, $urandom}, 8'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    step(); step();
    chk("sustained_no_drop", 64'(exp_q.size()), 64'd0);
    chk("sustained_count", 64'(nrsp), 64'(nrd));

    // Reset with three reads in flight.
    rsp_ready = 1'b0;
    send(1'b0, 17'h20, 64'h0, 8'h00);
    send(1'b0, 17'h28, 64'h0, 8'h00);
    send(1'b0, 17'h10, 64'h0, 8'h00);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    got_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_valid) bad = 1'b1;
    end
    chk("midreset_no_rsp", 64'(bad), 64'd0);
    send(1'b0, 17'h0010, 64'h0, 8'h00);
    wait_got(1);
    if (got_q.size() > 0) chk("midreset_new_read", got_q[0], 64'h01234567_89ABCDEF);
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
